// File: rtl/video_mnist_vote.sv
// -----------------------------------------------------------------------------
// video_mnist_vote
//
// Per-frame majority vote over a stream of MNIST classifier results. Every
// accepted beat carries a digit (tnumber) and a confidence (tcount). Beats
// whose digit is 0..9 and whose confidence reaches the programmable threshold
// are histogrammed. At each start-of-frame the finished histogram is frozen
// into shadow registers and scanned, one bin per cycle, for the most frequent
// digit. The winner, its count, the frame's beat total and a frame counter
// are published on a zero-wait Wishbone slave, and an optional irq pulses.
//
// Ports
//   reset            asynchronous active-high reset
//   clk              single clock for stream and Wishbone
//   s_axi4s_tuser    bit 0 marks the first beat of a frame
//   s_axi4s_tlast    end of line (not used by the vote)
//   s_axi4s_tnumber  classified digit
//   s_axi4s_tcount   classifier confidence
//   s_axi4s_tvalid   beat valid
//   s_axi4s_tready   beat accepted; low while the histogram is being scanned
//   s_wb_*           Wishbone slave; ack mirrors stb, reads are combinational
//   irq              one-cycle pulse after a new result is published
//
// Register map (word address)
//   0 CORE_ID (0x4D4E5654)   1 PARAM_TH       2 RESULT_NUMBER
//   3 RESULT_COUNT           4 RESULT_TOTAL   5 FRAME_COUNT
//   6 CTL: bit0 irq_en, bit1 write-1 clear (returns to IDLE)
//   all other addresses read 0
// -----------------------------------------------------------------------------
module video_mnist_vote #(
  parameter int TUSER_WIDTH   = 1,
  parameter int NUMBER_WIDTH  = 4,
  parameter int COUNT_WIDTH   = 4,
  parameter int HIST_WIDTH    = 20,
  parameter int WB_ADR_WIDTH  = 8,
  parameter int WB_DAT_WIDTH  = 32,
  parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
  parameter int INIT_PARAM_TH = 4
) (
  input  logic                    reset,
  input  logic                    clk,

  input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                    s_axi4s_tlast,
  input  logic [NUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [COUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic                    s_axi4s_tvalid,
  output logic                    s_axi4s_tready,

  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,

  output logic                    irq
);

  localparam int NUM_BINS = 10;
  localparam int SCAN_W   = $clog2(NUM_BINS);

  localparam logic [SCAN_W-1:0]       SCAN_LAST = SCAN_W'(NUM_BINS - 1);
  // All-ones digit (15 for a 4-bit digit) means "no eligible beat this frame".
  localparam logic [NUMBER_WIDTH-1:0] NO_WINNER = '1;
  localparam logic [31:0]             CORE_ID   = 32'h4D4E_5654;

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID = WB_ADR_WIDTH'(0);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH      = WB_ADR_WIDTH'(1);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_NUMBER  = WB_ADR_WIDTH'(2);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_COUNT   = WB_ADR_WIDTH'(3);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TOTAL   = WB_ADR_WIDTH'(4);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAMES  = WB_ADR_WIDTH'(5);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL     = WB_ADR_WIDTH'(6);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN
  } state_t;

  state_t                   state, state_next;

  logic [HIST_WIDTH-1:0]    live_bins   [NUM_BINS];
  logic [HIST_WIDTH-1:0]    bins_next   [NUM_BINS];
  logic [HIST_WIDTH-1:0]    live_total, total_next;
  logic [HIST_WIDTH-1:0]    shadow_bins [NUM_BINS];
  logic [HIST_WIDTH-1:0]    shadow_total;

  logic [SCAN_W-1:0]        scan_idx;
  logic [NUMBER_WIDTH-1:0]  best_num, cand_num;
  logic [HIST_WIDTH-1:0]    best_cnt, cand_cnt;
  logic                     scan_last;

  logic [NUMBER_WIDTH-1:0]  result_number;
  logic [HIST_WIDTH-1:0]    result_count;
  logic [HIST_WIDTH-1:0]    result_total;
  logic [31:0]              frame_count;

  logic [COUNT_WIDTH-1:0]   param_th, param_th_wr;
  logic                     irq_en, irq_en_wr;

  logic                     accept, sof, eligible;
  logic                     frame_start, snapshot, count_beat;
  logic                     wb_wr, ctl_clear;
  logic                     unused_inputs;

  // tlast and the upper write-data / byte-select bits carry nothing we need.
  assign unused_inputs = ^{s_axi4s_tlast, s_axi4s_tuser, s_wb_dat_i, s_wb_sel_i};

  function automatic logic [HIST_WIDTH-1:0] sat_inc(input logic [HIST_WIDTH-1:0] v);
    return (&v) ? v : v + HIST_WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Stream qualification
  // ---------------------------------------------------------------------------
  assign accept   = s_axi4s_tvalid && s_axi4s_tready;
  assign sof      = s_axi4s_tuser[0];
  assign eligible = (s_axi4s_tnumber < NUMBER_WIDTH'(NUM_BINS)) &&
                    (s_axi4s_tcount >= param_th);

  // A CTL clear in the same cycle as a beat wins: the beat is dropped.
  assign wb_wr     = s_wb_stb_i && s_wb_we_i;
  assign ctl_clear = wb_wr && (s_wb_adr_i == ADR_CTL) && s_wb_sel_i[0] && s_wb_dat_i[1];

  // A start-of-frame beat restarts the histogram from IDLE or RUN; from RUN it
  // also freezes the finished frame for scanning.
  assign frame_start = accept && sof && !ctl_clear &&
                       ((state == ST_IDLE) || (state == ST_RUN));
  assign snapshot    = frame_start && (state == ST_RUN);
  assign count_beat  = accept && !ctl_clear && ((state == ST_RUN) || frame_start);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of every other flop regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every variable gets its default at the top of a combinational block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept && sof)             state_next = ST_RUN;
      ST_RUN:  if (accept && sof)             state_next = ST_SCAN;
      ST_SCAN: if (scan_idx == SCAN_LAST)     state_next = ST_RUN;
      default:                                state_next = ST_IDLE;
    endcase
    if (ctl_clear) state_next = ST_IDLE;
  end

  // tready is registered from the next state so it is low throughout reset,
  // rises on the first edge after release and drops for exactly the scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_axi4s_tready <= 1'b0;
    end else begin
      s_axi4s_tready <= (state_next != ST_SCAN);
    end
  end

  // ---------------------------------------------------------------------------
  // Live histogram
  // ---------------------------------------------------------------------------
  always_comb begin
    bins_next  = live_bins;
    total_next = live_total;
    if (ctl_clear || (state == ST_IDLE) || frame_start) begin
      for (int i = 0; i < NUM_BINS; i++) bins_next[i] = '0;
      total_next = '0;
    end
    if (count_beat) begin
      total_next = sat_inc(total_next);
      if (eligible) begin
        bins_next[s_axi4s_tnumber] = sat_inc(bins_next[s_axi4s_tnumber]);
      end
    end
  end

  // NOTE: the bin arrays are reset explicitly; a reset abort mid-frame must
  // leave no stale counts behind, so they cannot be left as plain RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) live_bins[i] <= '0;
      live_total <= '0;
    end else begin
      live_bins  <= bins_next;
      live_total <= total_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan of the frozen histogram: strictly-greater keeps the lowest digit on a
  // tie, and starting from count 0 means an all-zero frame keeps NO_WINNER.
  // ---------------------------------------------------------------------------
  assign scan_last = (scan_idx == SCAN_LAST);

  always_comb begin
    cand_num = best_num;
    cand_cnt = best_cnt;
    if (shadow_bins[scan_idx] > best_cnt) begin
      cand_num = NUMBER_WIDTH'(scan_idx);
      cand_cnt = shadow_bins[scan_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) shadow_bins[i] <= '0;
      shadow_total  <= '0;
      scan_idx      <= '0;
      best_num      <= NO_WINNER;
      best_cnt      <= '0;
      result_number <= NO_WINNER;
      result_count  <= '0;
      result_total  <= '0;
      frame_count   <= '0;
      irq           <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (snapshot) begin
        shadow_bins  <= live_bins;
        shadow_total <= live_total;
        scan_idx     <= '0;
        best_num     <= NO_WINNER;
        best_cnt     <= '0;
      end else if ((state == ST_SCAN) && !ctl_clear) begin
        best_num <= cand_num;
        best_cnt <= cand_cnt;
        scan_idx <= scan_idx + SCAN_W'(1);
        if (scan_last) begin
          result_number <= cand_num;
          result_count  <= cand_cnt;
          result_total  <= shadow_total;
          frame_count   <= frame_count + 32'd1;
          irq           <= irq_en;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone slave
  // ---------------------------------------------------------------------------
  assign s_wb_ack_o = s_wb_stb_i;

  // Byte-lane merge: each register bit only changes when its lane is selected.
  always_comb begin
    param_th_wr = param_th;
    for (int i = 0; i < COUNT_WIDTH; i++) begin
      if (s_wb_sel_i[i / 8]) param_th_wr[i] = s_wb_dat_i[i];
    end
    irq_en_wr = s_wb_sel_i[0] ? s_wb_dat_i[0] : irq_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      param_th <= COUNT_WIDTH'(INIT_PARAM_TH);
      irq_en   <= 1'b0;
    end else if (wb_wr) begin
      if (s_wb_adr_i == ADR_TH)  param_th <= param_th_wr;
      if (s_wb_adr_i == ADR_CTL) irq_en   <= irq_en_wr;
    end
  end

  always_comb begin
    s_wb_dat_o = '0;
    unique case (s_wb_adr_i)
      ADR_CORE_ID: s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
      ADR_TH:      s_wb_dat_o = WB_DAT_WIDTH'(param_th);
      ADR_NUMBER:  s_wb_dat_o = WB_DAT_WIDTH'(result_number);
      ADR_COUNT:   s_wb_dat_o = WB_DAT_WIDTH'(result_count);
      ADR_TOTAL:   s_wb_dat_o = WB_DAT_WIDTH'(result_total);
      ADR_FRAMES:  s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
      ADR_CTL:     s_wb_dat_o = WB_DAT_WIDTH'(irq_en);
      default:     s_wb_dat_o = '0;
    endcase
  end

endmodule

// File: doc/video_mnist_vote.md
VIDEO_MNIST_VOTE -- requirements
Module: video_mnist_vote

Interface
REQ-001 Parameters SHALL be:
- TUSER_WIDTH, 1, stream user width; bit 0 marks start of frame.
- NUMBER_WIDTH, 4, classifier digit width.
- COUNT_WIDTH, 4, classifier confidence width.
- HIST_WIDTH, 20, histogram bin and total width.
- WB_ADR_WIDTH, 8, Wishbone word-address width.
- WB_DAT_WIDTH, 32, Wishbone data width.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width.
- INIT_PARAM_TH, 4, reset value of the confidence threshold.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- reset  in  1  asynchronous active-high reset.
- clk  in  1  sole clock; stream and Wishbone both synchronous to it.
- s_axi4s_tuser  in  TUSER_WIDTH  bit 0 = first beat of frame.
- s_axi4s_tlast  in  1  end of line; ignored.
- s_axi4s_tnumber  in  NUMBER_WIDTH  classified digit.
- s_axi4s_tcount  in  COUNT_WIDTH  classifier confidence.
- s_axi4s_tvalid  in  1  beat valid.
- s_axi4s_tready  out  1  beat accepted.
- s_wb_adr_i  in  WB_ADR_WIDTH  word address.
- s_wb_dat_i  in  WB_DAT_WIDTH  write data.
- s_wb_dat_o  out  WB_DAT_WIDTH  read data.
- s_wb_we_i  in  1  write enable.
- s_wb_sel_i  in  WB_SEL_WIDTH  byte lane enables.
- s_wb_stb_i  in  1  strobe.
- s_wb_ack_o  out  1  acknowledge.
- irq  out  1  one-cycle pulse when a new result is published.

Function
REQ-004 Beat acceptance SHALL be defined as s_axi4s_tvalid && s_axi4s_tready.
REQ-005 Histogram: 10 live bins for digits 0..9; an accepted beat with tnumber<=9 and tcount>=param_th SHALL increment bin[tnumber], saturating at all-ones.
REQ-006 tnumber>=10 SHALL never touch bins; every accepted beat SHALL increment the saturating live total.
REQ-007 FSM states SHALL be IDLE, RUN and SCAN.
REQ-008 IDLE SHALL hold bins cleared; an accepted beat with tuser[0]=1 enters RUN and is counted as the first beat; beats before the first tuser are discarded.
REQ-009 In RUN, an accepted beat with tuser[0]=1 SHALL copy bins and total to shadow registers, clear live bins, count the current beat into the cleared bins, and enter SCAN.
REQ-010 SCAN SHALL take exactly 10 cycles, comparing shadow bin 0..9 one per cycle; strictly-greater comparison, so ties resolve to the lowest digit.
REQ-011 On the last SCAN cycle the block SHALL update result_number, result_count (winning bin value), result_total (shadow total) and increment frame_count (wraps at 2^32), then return to RUN.
REQ-012 irq SHALL pulse for exactly one cycle, on the cycle after results update, when ctl_irq_en=1.
REQ-013 s_axi4s_tready SHALL be 1 in IDLE and RUN and 0 in SCAN, giving a 10-cycle stall per frame.
REQ-014 Result latency SHALL be 11 cycles from the tuser beat to the updated registers being readable.
REQ-015 A frame with all eligible bins zero SHALL publish result_number=15 and result_count=0.
REQ-016 Wishbone s_wb_ack_o SHALL equal s_wb_stb_i (zero wait); reads are combinational from the address.
REQ-017 Writes SHALL honour s_wb_sel_i per byte lane.
REQ-018 Register map (word address):
- 0: CORE_ID 0x4D4E5654, read-only.
- 1: PARAM_TH, read/write, COUNT_WIDTH bits.
- 2: RESULT_NUMBER, read-only.
- 3: RESULT_COUNT, read-only.
- 4: RESULT_TOTAL, read-only.
- 5: FRAME_COUNT, read-only.
- 6: CTL, bit0 irq_en read/write; writing bit1=1 forces the FSM to IDLE and clears live bins (self-clearing).
- Unmapped addresses read 0.
REQ-019 A PARAM_TH write SHALL take effect on the next accepted beat; it SHALL NOT alter beats already counted.
REQ-020 If a CTL clear and a beat acceptance coincide, the clear SHALL win and the beat is discarded.

Reset
REQ-021 While reset=1: FSM=IDLE, all bins and shadows=0, result_number=15, result_count=0, result_total=0, frame_count=0, param_th=INIT_PARAM_TH, irq_en=0, irq=0, s_axi4s_tready=0.
REQ-022 After reset release, s_axi4s_tready SHALL go to 1 on the first clk edge.
REQ-023 Reset asserted mid-SCAN SHALL abort the scan without publishing any result.

Verification
REQ-024 Frame of 16 beats (tuser on beat 0), tnumber=7 on 9 beats and 3 on 7, tcount=8, then a tuser beat -> after 11 cycles RESULT_NUMBER=7, RESULT_COUNT=9, RESULT_TOTAL=16, FRAME_COUNT=1, irq pulses once with irq_en=1.
REQ-025 Tie case, digits 2 and 5 each 4 beats -> RESULT_NUMBER=2.
REQ-026 PARAM_TH=9 with all tcount=8 -> RESULT_NUMBER=15, RESULT_COUNT=0, RESULT_TOTAL equals beat count.
REQ-027 tvalid held high continuously across a frame boundary -> tready low for exactly 10 cycles; no beat lost or duplicated; the next frame's total includes its tuser beat.
REQ-028 tnumber=12 beats -> no bin change, total increments; CTL bit1 write mid-frame -> IDLE, following beats discarded until the next tuser.
REQ-029 Reset pulse during SCAN -> all registers at reset values; no irq.
